// File: rtl/sata_dma_fis_framer_pkg.sv
// Shared definitions for the DMA read-side FIS framer: Data FIS header and framer states.
package sata_dma_pkg;

    localparam logic [7:0]  FIS_TYPE_DATA = 8'h46;
    localparam logic [31:0] FIS_HDR_DATA  = {24'h00_0000, FIS_TYPE_DATA};

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        DATA
    } framer_state_t;

endpackage

// File: rtl/sata_dma_fis_framer_if.sv
// Command, payload-in and framed-out streams of the DMA FIS framer.
interface sata_dma_fis_framer_if #(
    parameter int DWIDTH = 32,
    parameter int LWIDTH = 16
);
    logic [LWIDTH-1:0] cmd_len;
    logic              cmd_val;
    logic              cmd_rdy;
    logic [DWIDTH-1:0] wr_dat;
    logic              wr_val;
    logic              wr_rdy;
    logic [DWIDTH-1:0] rd_dat;
    logic              rd_val;
    logic              rd_sop;
    logic              rd_eop;
    logic              rd_rdy;
    logic              busy;

    modport master (
        output cmd_len, cmd_val, wr_dat, wr_val, rd_rdy,
        input  cmd_rdy, wr_rdy, rd_dat, rd_val, rd_sop, rd_eop, busy
    );

    modport slave (
        input  cmd_len, cmd_val, wr_dat, wr_val, rd_rdy,
        output cmd_rdy, wr_rdy, rd_dat, rd_val, rd_sop, rd_eop, busy
    );
endinterface

// File: rtl/sata_dma_fis_framer.sv
// Splits a per-command dword payload stream into SATA Data FIS frames (header + up to FISMAX dwords).
module sata_dma_fis_framer
    import sata_dma_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int FISMAX = 2048,
    parameter int LWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sata_dma_fis_framer_if.slave bus
);

    localparam int FWIDTH = $clog2(FISMAX) + 1;

    framer_state_t     state;
    logic [LWIDTH-1:0] rem;
    logic [FWIDTH-1:0] fcnt;
    logic [FWIDTH-1:0] fcnt_init;
    logic              ld;
    logic              wr_fire;

    assign ld          = ~bus.rd_val | bus.rd_rdy;
    assign bus.wr_rdy  = (state == DATA) & ld;
    assign wr_fire     = bus.wr_val & bus.wr_rdy;

    always_comb begin
        fcnt_init = FWIDTH'(rem);
        if (rem > LWIDTH'(FISMAX))
            fcnt_init = FWIDTH'(FISMAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rem        <= '0;
            fcnt       <= '0;
            bus.rd_dat <= '0;
            bus.rd_val <= 1'b0;
            bus.rd_sop <= 1'b0;
            bus.rd_eop <= 1'b0;
            bus.busy   <= 1'b0;
            bus.cmd_rdy <= 1'b0;
        end else begin
            // A taken (or empty) output slot is emptied unless a new dword lands below.
            if (ld)
                bus.rd_val <= 1'b0;

            case (state)
                IDLE: begin
                    bus.cmd_rdy <= 1'b1;
                    if (bus.cmd_val && bus.cmd_rdy && (bus.cmd_len != '0)) begin
                        rem         <= bus.cmd_len;
                        state       <= HEAD;
                        bus.busy    <= 1'b1;
                        bus.cmd_rdy <= 1'b0;
                    end
                end
                HEAD: begin
                    if (ld) begin
                        bus.rd_dat <= DWIDTH'(FIS_HDR_DATA);
                        bus.rd_sop <= 1'b1;
                        bus.rd_eop <= 1'b0;
                        bus.rd_val <= 1'b1;
                        fcnt       <= fcnt_init;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (wr_fire) begin
                        bus.rd_dat <= bus.wr_dat;
                        bus.rd_sop <= 1'b0;
                        bus.rd_eop <= (fcnt == FWIDTH'(1));
                        bus.rd_val <= 1'b1;
                        fcnt       <= fcnt - FWIDTH'(1);
                        rem        <= rem - LWIDTH'(1);
                        // End of transfer wins over end of frame, so no empty trailing header.
                        if (rem == LWIDTH'(1)) begin
                            state       <= IDLE;
                            bus.busy    <= 1'b0;
                            bus.cmd_rdy <= 1'b1;
                        end else if (fcnt == FWIDTH'(1)) begin
                            state <= HEAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sata_dma_fis_framer.md
Name: sata_dma_fis_framer

Overview:
- Read-side consumer of the DMA clock-domain-crossing buffer; sits between that buffer's output stream and the transport layer in the link clock domain.
- Per transfer command, splits the incoming dword payload stream into SATA Data FIS frames. Each frame is one header dword followed by at most FISMAX payload dwords, marked with sop/eop.
- Registered output stage with full valid/ready backpressure.

Parameters:
- DWIDTH, 32, stream width; only 32 is supported.
- FISMAX, 2048, maximum payload dwords per Data FIS (8192 bytes).
- LWIDTH, 16, width of the transfer length in dwords.

Ports:
- clk  input  1  single clock (link domain).
- reset  input  1  asynchronous, active-low reset.
- cmd_len  input  LWIDTH  transfer length in dwords.
- cmd_val  input  1  command valid.
- cmd_rdy  output  1  command accepted when cmd_val & cmd_rdy.
- wr_dat  input  DWIDTH  payload dword from the resync buffer.
- wr_val  input  1  payload valid.
- wr_rdy  output  1  payload ready.
- rd_dat  output  DWIDTH  framed dword.
- rd_val  output  1  framed dword valid.
- rd_sop  output  1  first dword of a FIS (header).
- rd_eop  output  1  last dword of a FIS.
- rd_rdy  input  1  downstream ready.
- busy  output  1  transfer in progress.

Behaviour:
- Reset (reset=0, async): state=IDLE; counters=0; rd_dat, rd_val, rd_sop, rd_eop, wr_rdy, busy = 0; cmd_rdy=0 while reset is asserted.
- Output register "load enable" ld = ~rd_val | rd_rdy. Output flags change only on ld. If nothing is loaded on ld, rd_val clears.
- States:
  - IDLE: cmd_rdy=1. On cmd_val, latch rem=cmd_len. If cmd_len=0, stay in IDLE with no output. Otherwise go to HEAD; busy=1 from the next cycle.
  - HEAD: on ld, load rd_dat=32'h0000_0046, rd_sop=1, rd_eop=0, rd_val=1. Set fcnt=min(rem,FISMAX). Go to DATA.
  - DATA: wr_rdy=ld. On wr_val & wr_rdy, load the dword with rd_sop=0 and rd_eop=(fcnt==1); decrement fcnt and rem.
    - If fcnt==1 and rem>1 at the transfer: go to HEAD.
    - If rem==1 at the transfer: go to IDLE; busy drops the same cycle.
- wr_rdy=0 outside DATA. Payload is never consumed without a free output slot.
- Latency: one clk from accepted input (or header generation) to rd_val.
- Throughput: one dword per clk when wr_val=rd_rdy=1. No bubbles between header and payload, or between consecutive FIS.
- Input starvation (wr_val=0 in DATA): rd_val drops after the held dword is taken. Counters hold.
- Downstream stall (rd_rdy=0): rd_dat, rd_val, rd_sop, rd_eop hold stable; wr_rdy=0.
- rem is LWIDTH bits. fcnt is $clog2(FISMAX)+1 bits so that FISMAX itself is representable.
- cmd_len exactly a multiple of FISMAX: produces exactly len/FISMAX frames, with no empty trailing header.
- Commands arriving while busy: cmd_rdy=0, so they are not accepted. Acceptance is allowed in the same cycle the last dword loads only if the state is already IDLE, i.e. on the next cycle.
- Reset mid-transfer: the frame is abandoned immediately and all outputs go to their reset values. Upstream data is not flushed by this block.

Decomposition:
- Shared package sata_dma_pkg holds:
  - localparam FIS_TYPE_DATA = 8'h46.
  - Header dword constant.
  - Framer state enum {IDLE, HEAD, DATA}.
- No sub-module is needed. The output register may optionally be factored as sata_dma_out_reg (valid/ready pipeline register with sideband), but it is kept inline by default.

Test Plan:
- cmd_len=4, wr_val and rd_rdy held at 1, payload 1..4 -> exactly 5 dwords, back-to-back:
  - 0x00000046 with sop=1.
  - 1, 2, 3.
  - 4 with eop=1.
  - busy low afterwards; cmd_rdy returns to 1.
- cmd_len=2049 (FISMAX=2048) -> two frames:
  - Frame 1: header + 2048 dwords; eop on dword 2048.
  - Frame 2: header + 1 dword, which carries eop.
  - Total 2051 output beats, zero bubbles.
- cmd_len=4096 -> exactly two frames of header+2048; no third header.
- cmd_len=0 -> accepted in 1 cycle; rd_val stays 0; busy stays 0.
- cmd_len=8, rd_rdy toggling 1010..., wr_val random -> output data order preserved and held stable while stalled; sop/eop counts each equal 1; scoreboard matches.
- reset pulled low after 3 payload dwords of a cmd_len=10 transfer -> all outputs 0 asynchronously. After release, a new cmd_len=2 produces a clean header+2.
